// File: rtl/dequant_skew_feeder_pkg.sv
// Shared defaults, saturation helpers and FSM encoding for the
// dequantizing skew feeder and its per-lane requantizer.
package dequant_skew_feeder_pkg;

    localparam int DEF_ARRAY_SIZE       = 8;
    localparam int DEF_DATA_WIDTH       = 8;
    localparam int DEF_INPUT_DATA_WIDTH = 16;
    localparam int DEF_SHIFT            = 4;

    // Largest and smallest signed operand values for a given width
    function automatic int sat_hi(input int width);
        return (1 << (width - 1)) - 1;
    endfunction

    function automatic int sat_lo(input int width);
        return -(1 << (width - 1));
    endfunction

    localparam int SAT_MAX = sat_hi(DEF_DATA_WIDTH);
    localparam int SAT_MIN = sat_lo(DEF_DATA_WIDTH);

    // Feeder FSM encoding
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_STREAM = 2'd1;
    localparam logic [1:0] ST_DRAIN  = 2'd2;

endpackage

// File: rtl/dequant_skew_feeder_requant_sat.sv
// Single-lane requantizer: Q8.8 -> Q4.4 with round-half-up and
// saturation to the signed operand range. Purely combinational.
module requant_sat
    import dequant_skew_feeder_pkg::*;
#(
    parameter int INPUT_DATA_WIDTH = DEF_INPUT_DATA_WIDTH,
    parameter int DATA_WIDTH       = DEF_DATA_WIDTH,
    parameter int SHIFT            = DEF_SHIFT
) (
    input  logic [INPUT_DATA_WIDTH-1:0] x,
    output logic [DATA_WIDTH-1:0]       y
);

    localparam int SAT_HI    = sat_hi(DATA_WIDTH);
    localparam int SAT_LO    = sat_lo(DATA_WIDTH);
    localparam int ROUND_INT = 1 << (SHIFT - 1);

    // One extra bit keeps x + half-LSB from wrapping at the positive limit
    localparam logic signed [INPUT_DATA_WIDTH:0] ROUND_X  = ROUND_INT[INPUT_DATA_WIDTH:0];
    localparam logic signed [INPUT_DATA_WIDTH:0] SAT_HI_X = SAT_HI[INPUT_DATA_WIDTH:0];
    localparam logic signed [INPUT_DATA_WIDTH:0] SAT_LO_X = SAT_LO[INPUT_DATA_WIDTH:0];

    logic signed [INPUT_DATA_WIDTH:0] widened;
    logic signed [INPUT_DATA_WIDTH:0] rounded;
    logic signed [INPUT_DATA_WIDTH:0] shifted;

    assign widened = {x[INPUT_DATA_WIDTH-1], x};
    assign rounded = widened + ROUND_X;
    assign shifted = rounded >>> SHIFT;

    // Clamp the shifted value into the operand range
    always_comb begin
        // NOTE: y gets a default before any branch so no path leaves it unassigned (no latch).
        y = shifted[DATA_WIDTH-1:0];
        if (shifted > SAT_HI_X) begin
            y = SAT_HI_X[DATA_WIDTH-1:0];
        end else if (shifted < SAT_LO_X) begin
            y = SAT_LO_X[DATA_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/dequant_skew_feeder.sv
// Accepts Q8.8 activation vectors, requantizes each lane to Q4.4 and
// feeds the systolic array west edge with a diagonal skew: row r sees its
// operand r cycles after row 0. Flags tile completion when the last
// skewed element leaves.
module dequant_skew_feeder
    import dequant_skew_feeder_pkg::*;
#(
    parameter int ARRAY_SIZE       = DEF_ARRAY_SIZE,
    parameter int DATA_WIDTH       = DEF_DATA_WIDTH,
    parameter int INPUT_DATA_WIDTH = DEF_INPUT_DATA_WIDTH,
    parameter int SHIFT            = DEF_SHIFT
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [ARRAY_SIZE*INPUT_DATA_WIDTH-1:0] in_data,
    input  logic                                   in_last,
    output logic [ARRAY_SIZE*DATA_WIDTH-1:0]       out_data,
    output logic [ARRAY_SIZE-1:0]                  out_valid,
    output logic                                   busy,
    output logic                                   done
);

    // Drain lasts ARRAY_SIZE-1 cycles; counter runs 0..DRAIN_LAST
    localparam int CNT_W      = (ARRAY_SIZE > 2) ? $clog2(ARRAY_SIZE - 1) : 1;
    localparam int DRAIN_LAST = (ARRAY_SIZE > 1) ? ARRAY_SIZE - 2 : 0;
    localparam logic [CNT_W-1:0] DRAIN_LAST_C = DRAIN_LAST[CNT_W-1:0];

    logic [1:0]       state;
    logic [CNT_W-1:0] drain_cnt;
    logic             handshake;
    logic [DATA_WIDTH-1:0] conv [ARRAY_SIZE];

    assign in_ready  = (state != ST_DRAIN);
    assign busy      = (state != ST_IDLE);
    assign handshake = in_valid && in_ready;

    // Per-lane requantization of the incoming vector
    for (genvar l = 0; l < ARRAY_SIZE; l++) begin : g_lane
        requant_sat #(
            .INPUT_DATA_WIDTH(INPUT_DATA_WIDTH),
            .DATA_WIDTH      (DATA_WIDTH),
            .SHIFT           (SHIFT)
        ) u_requant (
            .x(in_data[l*INPUT_DATA_WIDTH +: INPUT_DATA_WIDTH]),
            .y(conv[l])
        );
    end

    // Skew delay lines: row r is r+1 register stages deep. A stage without
    // a handshake carries a bubble (zero data, valid low), so invalid rows
    // always drive zero on out_data.
    for (genvar r = 0; r < ARRAY_SIZE; r++) begin : g_row
        logic [DATA_WIDTH-1:0] dq [0:r];
        logic                  vq [0:r];

        // Shift the row's operand and valid one stage per clock
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                // NOTE: the delay-line storage is reset too, so no partial tile survives a reset.
                for (int k = 0; k <= r; k++) begin
                    dq[k] <= '0;
                    vq[k] <= 1'b0;
                end
            end else begin
                // NOTE: non-blocking assignments let every stage sample its neighbour's old value.
                dq[0] <= handshake ? conv[r] : '0;
                vq[0] <= handshake;
                for (int k = 1; k <= r; k++) begin
                    dq[k] <= dq[k-1];
                    vq[k] <= vq[k-1];
                end
            end
        end

        assign out_data[r*DATA_WIDTH +: DATA_WIDTH] = dq[r];
        assign out_valid[r]                         = vq[r];
    end

    // Tile FSM: stream vectors, then drain the skew before signalling done
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            drain_cnt <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE, ST_STREAM: begin
                    if (handshake) begin
                        if (in_last) begin
                            if (ARRAY_SIZE == 1) begin
                                state <= ST_IDLE;
                                done  <= 1'b1;
                            end else begin
                                state     <= ST_DRAIN;
                                drain_cnt <= '0;
                            end
                        end else begin
                            state <= ST_STREAM;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt == DRAIN_LAST_C) begin
                        state <= ST_IDLE;
                        done  <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dequant_skew_feeder.sv
// Directed testbench for dequant_skew_feeder (ARRAY_SIZE = 8, SHIFT = 4).
// Expected operands are given per vector; a small history of accepted
// vectors predicts what each skewed row shows every cycle.
module tb_dequant_skew_feeder;

    localparam int AS = 8;
    localparam int DW = 8;
    localparam int IW = 16;
    localparam int HN = 512;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [AS*IW-1:0]  in_data;
    logic              in_last;
    logic [AS*DW-1:0]  out_data;
    logic [AS-1:0]     out_valid;
    logic              busy;
    logic              done;

    dequant_skew_feeder dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_last  (in_last),
        .out_data (out_data),
        .out_valid(out_valid),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_fail;

    // Bench-side expectation state
    logic [AS*DW-1:0] hist_d [HN];
    logic             hist_v [HN];
    int               cyc;
    int               last_edge;
    logic             in_tile;
    logic             exp_ready;
    logic             exp_done;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [AS*IW-1:0] skew_in(input int k);
        logic [AS*IW-1:0] v;
        v = '0;
        for (int r = 0; r < AS; r++) v[r*IW +: IW] = 16'(16 * (10 * k + r));
        return v;
    endfunction

    function automatic logic [AS*DW-1:0] skew_exp(input int k);
        logic [AS*DW-1:0] v;
        v = '0;
        for (int r = 0; r < AS; r++) v[r*DW +: DW] = 8'(10 * k + r);
        return v;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < HN; i++) begin
            hist_d[i] = '0;
            hist_v[i] = 1'b0;
        end
        last_edge = -1;
        in_tile   = 1'b0;
        exp_ready = 1'b1;
        exp_done  = 1'b0;
    endtask

    task automatic check_outputs();
        int idx;
        logic ev;
        logic [DW-1:0] ed;
        for (int r = 0; r < AS; r++) begin
            idx = cyc - r;
            ev  = (idx >= 0) ? hist_v[idx] : 1'b0;
            ed  = ev ? hist_d[idx][r*DW +: DW] : '0;
            check($sformatf("row%0d_valid@%0d", r, cyc), 64'(out_valid[r]), 64'(ev));
            check($sformatf("row%0d_data@%0d", r, cyc), 64'(out_data[r*DW +: DW]), 64'(ed));
        end
        check($sformatf("done@%0d", cyc), 64'(done), 64'(exp_done));
        check($sformatf("busy@%0d", cyc), 64'(busy), 64'(in_tile));
        check($sformatf("in_ready@%0d", cyc), 64'(in_ready), 64'(exp_ready));
    endtask

    // Present one input cycle, clock it, then check every output
    task automatic cycle(input logic v, input logic last,
                         input logic [AS*IW-1:0] lanes, input logic [AS*DW-1:0] expv);
        logic acc;
        in_valid = v;
        in_last  = last;
        in_data  = lanes;
        acc      = v && exp_ready;
        @(posedge clk);
        #1;
        cyc++;
        hist_v[cyc] = acc;
        hist_d[cyc] = acc ? expv : '0;
        if (acc && last) last_edge = cyc;
        if (last_edge >= 0 && cyc == last_edge + AS - 1) in_tile = 1'b0;
        if (acc) in_tile = 1'b1;
        exp_done  = (last_edge >= 0) && (cyc == last_edge + AS - 1);
        exp_ready = !((last_edge >= 0) && (cyc >= last_edge) && (cyc <= last_edge + AS - 2));
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, {AS{16'h1234}}, '0);
    endtask

    task automatic mid_reset();
        #2;
        rst      = 1'b1;
        in_valid = 1'b0;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_hold_valid", 64'(out_valid), 64'd0);
        rst = 1'b0;
        #1;
        check("rst_release_ready", 64'(in_ready), 64'd1);
        check("rst_release_busy", 64'(busy), 64'd0);
        clear_model();
        cyc = cyc + 2;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
        clear_model();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_out_data", 64'(out_data), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_in_ready", 64'(in_ready), 64'd1);

        // Rounding and saturation: single-vector tile
        //   lanes 7FFF 8000 24 23 -24 -25 -8 8 -> 127 -128 2 1 -1 -2 0 1
        cycle(1'b1, 1'b1,
              {16'h0008, 16'hFFF8, 16'hFFE7, 16'hFFE8, 16'h0017, 16'h0018, 16'h8000, 16'h7FFF},
              {8'h01, 8'h00, 8'hFE, 8'hFF, 8'h01, 8'h02, 8'h80, 8'h7F});
        idle(9);

        // Skew alignment: three back-to-back vectors, last on the third
        for (int k = 0; k < 3; k++) cycle(1'b1, k == 2, skew_in(k), skew_exp(k));
        idle(9);

        // Bubbles: two idle cycles between two vectors
        cycle(1'b1, 1'b0, skew_in(3), skew_exp(3));
        idle(2);
        cycle(1'b1, 1'b1, skew_in(4), skew_exp(4));
        idle(9);

        // Drain back-pressure with in_valid held, then a new tile in the done cycle
        cycle(1'b1, 1'b1, skew_in(5), skew_exp(5));
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1, skew_in(6), skew_exp(6));
        idle(9);

        // Reset mid-tile after four vectors, then recovery
        for (int k = 7; k < 11; k++) cycle(1'b1, 1'b0, skew_in(k), skew_exp(k));
        mid_reset();
        idle(10);
        cycle(1'b1, 1'b1, skew_in(11), skew_exp(11));
        idle(9);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
